// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared select-width derivation and destination-mask helper.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int MAX_OUT = 16;

    typedef logic [MAX_OUT-1:0] mask_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } dmx_state_t;

    // Select width is max(1, clog2(n)).
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One-hot of sel for unicast, all ones across n channels for broadcast,
    // and zero when a unicast select lies outside the channel range.
    function automatic mask_t dest_mask(input logic bcast, input int sel, input int n);
        mask_t m;
        m = '0;
        if (bcast) begin
            m = mask_t'((32'd1 << n) - 32'd1);
        end else if (sel < n) begin
            m = mask_t'(1) << sel;
        end
        return m;
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1n_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_1n_stream_if
// Purpose  : Upstream stream, per-channel downstream bus and drop counter.
// Revision : 1.0
// ============================================================================
interface demux_1n_stream_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
);
    import demux_pkg::*;

    localparam int SEL_W = sel_width(N_OUT);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [7:0]              drop_cnt;

    // Environment side: drives the upstream word and downstream readies.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    // Demux side.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );

endinterface : demux_1n_stream_if
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter8
// Purpose  : 8-bit enable-driven counter that sticks at 255.
// Revision : 1.0
// ============================================================================
module sat_counter8 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       en_i,
    output logic [7:0]      cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter8
`default_nettype wire

// File: rtl/demux_1n_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1n_stream
// Purpose  : One-word 1:N stream demux with unicast/broadcast and drop count.
// Revision : 1.0
// ============================================================================
module demux_1n_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    demux_1n_stream_if.slave bus
);

    localparam int SEL_W = sel_width(N_OUT);

    logic [N_OUT-1:0]  pending_q;
    logic [N_OUT-1:0]  pending_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    dmx_state_t        state;
    mask_t             full_mask;
    logic [N_OUT-1:0]  blocked;
    logic              in_ready_c;
    logic              handshake;
    logic              drop_en;

    // Next-state and handshake decode; state is a view of the pending mask.
    always_comb begin
        state      = (pending_q == '0) ? ST_IDLE : ST_HOLD;
        blocked    = pending_q & ~bus.out_ready;
        full_mask  = dest_mask(bus.in_bcast, 32'(bus.in_sel), N_OUT);
        in_ready_c = 1'b1;
        pending_d  = pending_q & ~bus.out_ready;
        data_d     = data_q;

        unique case (state)
            ST_IDLE: in_ready_c = 1'b1;
            ST_HOLD: in_ready_c = (blocked == '0);
            default: in_ready_c = 1'b1;
        endcase

        handshake = bus.in_valid & in_ready_c;

        // A fresh load wins over the final acceptance of the previous word.
        if (handshake) begin
            pending_d = full_mask[N_OUT-1:0];
            data_d    = bus.in_data;
        end

        // An empty destination mask only arises from an out-of-range unicast.
        drop_en = handshake & (full_mask == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    sat_counter8 u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (drop_en),
        .cnt_o (bus.drop_cnt)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = pending_q;
    assign bus.out_data  = {N_OUT{data_q}};

endmodule : demux_1n_stream
`default_nettype wire

// File: tb/tb_demux_1n_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1n_stream
// Purpose  : Self-checking bench for demux_1n_stream (N_OUT=4 and N_OUT=3).
// Revision : 1.0
// ============================================================================
module tb_demux_1n_stream;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1n_stream_if #(.DATA_W(DW), .N_OUT(4)) bus4 ();
    demux_1n_stream_if #(.DATA_W(DW), .N_OUT(3)) bus3 ();

    demux_1n_stream #(.DATA_W(DW), .N_OUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    demux_1n_stream #(.DATA_W(DW), .N_OUT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic       b;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [7:0] exp_d;
    } vec_t;

    vec_t       tbl [14];
    logic [3:0] m_pend;
    logic [7:0] sbq [4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic b, input logic [1:0] s,
                          input logic [7:0] d, input logic [3:0] ordy);
        bus4.in_valid  = v;
        bus4.in_bcast  = b;
        bus4.in_sel    = s;
        bus4.in_data   = d;
        bus4.out_ready = ordy;
    endtask

    // One random/scoreboard cycle on the 4-channel instance.
    task automatic rstep(input logic v, input logic b, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] ordy);
        logic       m_rdy;
        logic [3:0] m_next;
        logic [3:0] m_load;
        logic [7:0] e;
        @(negedge clk);
        drive4(v, b, s, d, ordy);
        #1;
        chk("rnd_out_valid", 32'(bus4.out_valid), 32'(m_pend));
        m_rdy = ((m_pend & ~ordy) == 4'b0000);
        chk("rnd_in_ready", 32'(bus4.in_ready), 32'(m_rdy));
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && ordy[i] && (sbq[i].size() != 0)) begin
                e = sbq[i].pop_front();
                chk("rnd_data", 32'(bus4.out_data[i*DW +: DW]), 32'(e));
            end
        end
        m_next = m_pend & ~ordy;
        if (v && m_rdy) begin
            m_load = b ? 4'b1111 : (4'b0001 << s);
            m_next = m_load;
            for (int i = 0; i < 4; i++) begin
                if (m_load[i]) sbq[i].push_back(d);
            end
        end
        m_pend = m_next;
        @(posedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 8'hA5};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'hA5};
        tbl[2]  = '{1'b1, 1'b1, 2'd0, 8'h3C, 4'b1011, 1'b1, 4'b1111, 8'h3C};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b0, 4'b0100, 8'h3C};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1011, 1'b0, 4'b0100, 8'h3C};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h3C};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 8'h10};
        tbl[7]  = '{1'b1, 1'b0, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 8'h11};
        tbl[8]  = '{1'b1, 1'b0, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0100, 8'h12};
        tbl[9]  = '{1'b1, 1'b0, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b1000, 8'h13};
        tbl[10] = '{1'b1, 1'b0, 2'd1, 8'h55, 4'b0000, 1'b0, 4'b1000, 8'h13};
        tbl[11] = '{1'b1, 1'b0, 2'd1, 8'h55, 4'b1000, 1'b1, 4'b0010, 8'h55};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0101, 1'b0, 4'b0010, 8'h55};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, 4'b0000, 8'h55};

        drive4(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        bus3.in_valid  = 1'b0;
        bus3.in_bcast  = 1'b0;
        bus3.in_sel    = 2'd0;
        bus3.in_data   = 8'h00;
        bus3.out_ready = 3'b111;

        // Reset state, before and after the first clock edge.
        #2;
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_drop_cnt", 32'(bus4.drop_cnt), 32'd0);
        chk("rst_out_data", bus4.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("post_rst_in_ready3", 32'(bus3.in_ready), 32'd1);

        // Table-driven: unicast, broadcast partial accept, streaming, priority.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive4(tbl[k].v, tbl[k].b, tbl[k].sel, tbl[k].d, tbl[k].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", k), 32'(bus4.in_ready), 32'(tbl[k].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", k), 32'(bus4.out_valid), 32'(tbl[k].exp_ov));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("vec%0d_slice%0d", k, i),
                    32'(bus4.out_data[i*DW +: DW]), 32'(tbl[k].exp_d));
            end
        end
        chk("n4_drop_cnt", 32'(bus4.drop_cnt), 32'd0);

        // N_OUT=3: out-of-range select is dropped and counted.
        @(negedge clk);
        bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_data = 8'h77;
        #1;
        chk("drop_in_ready", 32'(bus3.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("drop_out_valid", 32'(bus3.out_valid), 32'd0);
        chk("drop_cnt_1", 32'(bus3.drop_cnt), 32'd1);
        @(negedge clk);
        bus3.in_sel = 2'd1; bus3.in_data = 8'h42;
        @(posedge clk); #1;
        chk("n3_out_valid", 32'(bus3.out_valid), 32'b010);
        chk("n3_slice1", 32'(bus3.out_data[DW +: DW]), 32'h42);
        chk("n3_drop_hold", 32'(bus3.drop_cnt), 32'd1);
        @(negedge clk);
        bus3.in_sel = 2'd3;
        for (int n = 0; n < 299; n++) begin
            @(posedge clk); #1;
            if (n == 253) chk("drop_cnt_255", 32'(bus3.drop_cnt), 32'd255);
        end
        chk("drop_cnt_sat", 32'(bus3.drop_cnt), 32'd255);
        chk("drop_out_valid_sat", 32'(bus3.out_valid), 32'd0);
        @(negedge clk);
        bus3.in_valid = 1'b0;

        // Asynchronous reset while channel 1 holds a word.
        @(negedge clk);
        drive4(1'b1, 1'b0, 2'd1, 8'h99, 4'b0000);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 32'(bus4.out_valid), 32'b0010);
        bus4.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("arst_slice1", 32'(bus4.out_data[DW +: DW]), 32'd0);
        chk("arst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("arst_drop_cnt3", 32'(bus3.drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.out_ready = 4'b1111;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            chk("after_rst_no_output", 32'(bus4.out_valid), 32'd0);
        end

        // Random traffic against the per-channel scoreboard.
        m_pend = 4'b0000;
        for (int n = 0; n < 10000; n++) begin
            rstep(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom_range(0, 15)));
        end
        for (int n = 0; n < 3; n++) begin
            rstep(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
        end
        chk("sb_drained", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1n_stream
`default_nettype wire

// File: doc/demux_1n_stream.md
DEMUX_1N_STREAM -- requirements
Module: demux_1n_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits.
REQ-002 SHALL have parameter N_OUT, default 4: output channel count, legal range 2..16.
REQ-003 SHALL have localparam SEL_W = max(1, clog2(N_OUT)): select width.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: upstream word valid.
REQ-007 SHALL have port in_ready  output  1: block accepts the word this cycle.
REQ-008 SHALL have port in_data  input  DATA_W: upstream word.
REQ-009 SHALL have port in_sel  input  SEL_W: destination channel, unicast mode.
REQ-010 SHALL have port in_bcast  input  1: 1 = send the word to all channels.
REQ-011 SHALL have port out_valid  output  N_OUT: per-channel valid; bit i = channel i.
REQ-012 SHALL have port out_ready  input  N_OUT: per-channel downstream ready.
REQ-013 SHALL have port out_data  output  N_OUT*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port drop_cnt  output  8: count of dropped words.

Function
REQ-015 SHALL hold one word in a data register plus an N_OUT-bit pending mask; out_valid = pending.
REQ-016 SHALL drive every out_data slice from the same data register.
REQ-017 SHALL use FSM IDLE (pending = 0) and HOLD (pending != 0); state is derived from the mask.
REQ-018 SHALL drive in_ready = 1 when (pending & ~out_ready) == 0, i.e. IDLE, or HOLD with every pending bit accepted this cycle.
REQ-019 SHALL define a handshake as in_valid & in_ready; only then are data and mask loaded.
REQ-020 SHALL, for a unicast handshake with in_sel < N_OUT, load pending = one-hot(in_sel).
REQ-021 SHALL, for a broadcast handshake, load pending = all ones; in_sel is ignored.
REQ-022 SHALL clear pending bit i when out_valid[i] & out_ready[i], independently per channel, with no handshake that cycle.
REQ-023 SHALL give the new load priority over the clear when a handshake and the last acceptance coincide: back-to-back, one word per cycle.
REQ-024 SHALL, for a unicast handshake with in_sel >= N_OUT, accept the word, leave pending = 0, and increment drop_cnt.
REQ-025 SHALL saturate drop_cnt at 255.
REQ-026 SHALL have a latency of 1 cycle: out_valid rises on the cycle after the handshake.
REQ-027 SHALL keep out_data and pending stable while any pending bit is unaccepted.
REQ-028 SHALL ignore out_ready on channels whose pending bit is 0.

Reset
REQ-029 SHALL, on rst_n low, immediately clear pending, out_valid, data register, and drop_cnt to 0, regardless of clk.
REQ-030 SHALL drive in_ready = 1 during and after reset because pending = 0.
REQ-031 SHALL discard a word pending mid-operation on reset; no output pulse follows release.

Structure
REQ-032 SHALL take SEL_W derivation and the one-hot/all-ones mask helper from shared package demux_pkg.
REQ-033 SHALL implement drop_cnt in one sub-module, sat_counter8: enable input, saturating 8-bit count, asynchronous active-low clear.
REQ-034 SHALL require no other sub-modules.

Verification
REQ-035 SHALL pass this scenario with N_OUT=4 and all out_ready=1: in_sel=2, in_data=0xA5, one handshake -> next cycle out_valid=0100, slice 2 = 0xA5, then out_valid=0000.
REQ-036 SHALL pass this scenario: broadcast of 0x3C with out_ready=1011 -> out_valid 1111 then 0100 while in_ready=0; raise out_ready[2] -> out_valid=0000, in_ready=1.
REQ-037 SHALL pass this scenario: streaming in_sel 0,1,2,3 on 4 consecutive cycles with all ready -> out_valid 0001,0010,0100,1000 on consecutive cycles, in_ready constantly 1.
REQ-038 SHALL pass this scenario with N_OUT=3: in_sel=3 handshake -> no out_valid, drop_cnt=1; after 300 such words, drop_cnt=255.
REQ-039 SHALL pass this scenario: rst_n low mid-clock while out_valid=0010 and out_ready=0 -> out_valid=0000 and drop_cnt=0 before the next edge; no output after release.
REQ-040 SHALL pass this scenario: random in_valid/out_ready at 50% for 10000 cycles -> scoreboard sees every accepted word exactly once per destination, in order, with no loss.
